// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared controller types, instruction word layout and memory server FSM states.
package ctrl_pkg;
  typedef enum logic [2:0] {ADD, SUB, NEG, AND, OR, NOT, SHR, SHL} opc_t;
  typedef struct packed {
    opc_t       opcode;
    logic [3:0] reg_a;
    logic [3:0] reg_b;
    logic [4:0] cnt;
  } instr_t;
  localparam int OFFSET = 16;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} mem_state_t;
endpackage

// File: rtl/ctrl_mem_array.sv
// ctrl_mem_array: DEPTH x DW single-write-port RAM with registered, enable-gated read.
module ctrl_mem_array #(
  parameter int AW    = 5,
  parameter int DEPTH = 32,
  parameter int DW    = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [DEPTH];
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end
  // Read register holds between reads; it returns pre-edge contents on a same-edge write.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_rdata <= '0;
    else if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/ctrl_mem_server.sv
// ctrl_mem_server: REQ/ACK instruction/result memory with programmable wait states and preload port.
module ctrl_mem_server
  import ctrl_pkg::*;
#(
  parameter int AW      = 5,
  parameter int DEPTH   = 32,
  parameter int DW      = 16,
  parameter int LATENCY = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_req,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic          o_ack,
  output logic [DW-1:0] o_rdata,
  output logic          o_err,
  output logic          o_busy,
  input  logic          i_ld_en,
  input  logic [AW-1:0] i_ld_addr,
  input  logic [DW-1:0] i_ld_data
);
  localparam logic [3:0] LAT_LAST = 4'(LATENCY);
  mem_state_t    r_state, w_next;
  logic [3:0]    r_cnt;
  logic          r_we, r_zero, r_ack, r_err, r_busy;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata, w_arr_rdata, w_arr_wdata;
  logic [AW-1:0] w_arr_waddr;
  logic          w_cap, w_commit, w_oor, w_ld_ok, w_arr_we, w_rd;
  // The edge leaving RESP samples REQ like IDLE so back-to-back requests lose no cycle.
  always_comb begin
    w_cap       = (r_state == ST_IDLE || r_state == ST_RESP) && i_req;
    w_commit    = (r_state == ST_WAIT) && (r_cnt == LAT_LAST);
    w_next      = w_commit ? ST_RESP : (w_cap || r_state == ST_WAIT) ? ST_WAIT : ST_IDLE;
    w_oor       = 32'(r_addr) >= 32'(DEPTH);
    w_ld_ok     = i_ld_en && (32'(i_ld_addr) < 32'(DEPTH));
    w_arr_we    = w_ld_ok || (w_commit && r_we && !w_oor);
    w_arr_waddr = w_ld_ok ? i_ld_addr : r_addr;
    w_arr_wdata = w_ld_ok ? i_ld_data : r_wdata;
    w_rd        = w_commit && !r_we && !w_oor;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_zero  <= 1'b0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_cnt  <= w_cap ? 4'd0 : (r_state == ST_WAIT) ? r_cnt + 4'd1 : r_cnt;
      r_ack  <= w_commit;
      r_err  <= w_commit && w_oor;
      r_busy <= w_next != ST_IDLE;
      if (w_cap) begin
        r_we    <= i_we;
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
      end
      if (w_commit && !r_we) r_zero <= w_oor;
    end
  end
  ctrl_mem_array #(.AW(AW), .DEPTH(DEPTH), .DW(DW)) u_array (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_we    (w_arr_we),
    .i_waddr (w_arr_waddr),
    .i_wdata (w_arr_wdata),
    .i_re    (w_rd),
    .i_raddr (r_addr),
    .o_rdata (w_arr_rdata)
  );
  assign o_ack   = r_ack;
  assign o_err   = r_err;
  assign o_busy  = r_busy;
  assign o_rdata = r_zero ? '0 : w_arr_rdata;
endmodule
